// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback stream has priority, and
// MUL/DIV results wait in a small FIFO to fill idle slots, with WAW kill and starvation hold.
module wb_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we,
    input  logic [4:0]            pipe_rd,
    input  logic [DATA_WIDTH-1:0] pipe_data,
    input  logic                  md_valid,
    input  logic [4:0]            md_rd,
    input  logic [DATA_WIDTH-1:0] md_data,
    output logic                  md_ready,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    output logic                  raw_stall,
    output logic                  hold_req,
    output logic                  rf_we,
    output logic [4:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int SC_W  = $clog2(STARVE_MAX + 1);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [SC_W-1:0]  STARVE_SAT = SC_W'(STARVE_MAX);

    logic                  live_q [DEPTH];
    logic                  live_d [DEPTH];
    logic [4:0]            rd_q   [DEPTH];
    logic [4:0]            rd_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_d [DEPTH];

    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;
    logic [SC_W-1:0]       starve_q, starve_d;
    logic                  hold_q,   hold_d;
    logic                  rf_we_q,  rf_we_d;
    logic [4:0]            rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;

    logic                  fifo_empty;
    logic                  push;
    logic                  pop;
    logic                  raw_hit;

    assign fifo_empty = (count_q == '0);
    assign md_ready   = (count_q != FULL_CNT);
    // Pop decision uses the registered count, so a fresh push always sits one cycle.
    assign push       = md_valid && md_ready;
    assign pop        = !pipe_we && !fifo_empty;

    always_comb begin
        raw_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i] && (rd_q[i] != 5'd0) && ((rd_q[i] == rs1) || (rd_q[i] == rs2))) begin
                raw_hit = 1'b1;
            end
        end
    end

    assign raw_stall = raw_hit;
    assign hold_req  = hold_q;
    assign rf_we     = rf_we_q;
    assign rf_waddr  = rf_waddr_q;
    assign rf_wdata  = rf_wdata_q;

    always_comb begin
        live_d   = live_q;
        rd_d     = rd_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Kill older buffered results overwritten by the in-order pipeline.
        if (pipe_we && (pipe_rd != 5'd0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_q[i] == pipe_rd) begin
                    live_d[i] = 1'b0;
                end
            end
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        // Applied after the kill so a same-cycle push to pipe_rd survives as the younger value.
        if (push) begin
            live_d[wr_ptr_q] = (md_rd != 5'd0);
            rd_d[wr_ptr_q]   = md_rd;
            data_d[wr_ptr_q] = md_data;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (pipe_we) begin
            rf_we_d    = (pipe_rd != 5'd0);
            rf_waddr_d = pipe_rd;
            rf_wdata_d = pipe_data;
        end else if (pop) begin
            rf_we_d    = live_q[rd_ptr_q] && (rd_q[rd_ptr_q] != 5'd0);
            rf_waddr_d = rd_q[rd_ptr_q];
            rf_wdata_d = data_q[rd_ptr_q];
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (pipe_we && (starve_q != STARVE_SAT)) begin
            starve_d = starve_q + SC_W'(1);
        end
        hold_d = (starve_d >= STARVE_SAT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            hold_q     <= 1'b0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= 1'b0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            hold_q     <= hold_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            for (int i = 0; i < DEPTH; i++) begin
                live_q[i] <= live_d[i];
            end
        end
    end

    // Payload storage carries no reset; liveness alone decides whether an entry matters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            rd_q[i]   <= rd_d[i];
            data_q[i] <= data_d[i];
        end
    end

endmodule
